// File: rtl/d_mem_pkg.sv
// Shared constants and state encoding for the D-memory read/write interfaces.
package d_mem_pkg;

    localparam int unsigned ADDR_W    = 5;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MEM_DEPTH = 32;
    localparam int unsigned LAT_CNT_W = 3;

    // State bits double as output flags: [2]=busy, [1]=rd_enable, [0]=rd_done.
    localparam int unsigned ST_BUSY_BIT = 2;
    localparam int unsigned ST_EN_BIT   = 1;
    localparam int unsigned ST_DONE_BIT = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'b000,
        RD_SETUP = 3'b100,
        RD_WAIT  = 3'b110,
        RD_DONE  = 3'b101
    } rd_state_t;

endpackage

// File: rtl/d_mem_latency_counter.sv
// Loadable down-counter used to wait out the RAM's fixed read latency.
module d_mem_latency_counter
    import d_mem_pkg::*;
#(
    parameter int unsigned CNT_W = LAT_CNT_W
)
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero_c
);

    logic [CNT_W-1:0] r_cnt;

    // Load has priority over decrement.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);

endmodule

// File: rtl/d_memory_read_interface.sv
// One-shot read front-end for the 32x8 decrypted-message RAM.
// Optional burst reads are enabled by defining D_MEM_RD_BURST_EN.
module d_memory_read_interface
    import d_mem_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 2
)
(
    input  logic              clk,
    input  logic              nreset,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] addr_in,
`ifdef D_MEM_RD_BURST_EN
    input  logic [ADDR_W:0]   rd_len,
    output logic              rd_beat_valid,
`endif
    input  logic [DATA_W-1:0] rd_data_mem,
    output logic [ADDR_W-1:0] addr_mem,
    output logic              rd_enable,
    output logic [DATA_W-1:0] rd_data_out,
    output logic              rd_done,
    output logic              rd_busy
);

    // Latency must fit the 3-bit wait counter and be non-zero.
    if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
        $error("RD_LATENCY out of range 1..7");
    end

    rd_state_t         r_state;
    rd_state_t         w_state_next;
    logic              w_cnt_load;
    logic              w_cnt_dec;
    logic              w_cnt_zero_c;
    logic              w_capture;
    logic              w_last_beat;
    logic [ADDR_W-1:0] r_addr_mem;
    logic [DATA_W-1:0] r_rd_data_out;

    // Latency wait counter.
    d_mem_latency_counter #(
        .CNT_W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk        (clk),
        .nreset     (nreset),
        .i_load     (w_cnt_load),
        .i_load_val (LAT_CNT_W'(RD_LATENCY)),
        .i_dec      (w_cnt_dec),
        .o_zero_c   (w_cnt_zero_c)
    );

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and counter control.
    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_start) begin
                    w_state_next = RD_SETUP;
                end
            end
            RD_SETUP: begin
                w_cnt_load   = 1'b1;
                w_state_next = RD_WAIT;
            end
            RD_WAIT: begin
                if (!w_cnt_zero_c) begin
                    w_cnt_dec = 1'b1;
                end else begin
                    w_capture = 1'b1;
                    if (w_last_beat) begin
                        w_state_next = RD_DONE;
                    end else begin
                        w_cnt_load = 1'b1;
                    end
                end
            end
            RD_DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Address latch / advance and read-data capture.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_addr_mem    <= '0;
            r_rd_data_out <= '0;
        end else begin
            if (r_state == RD_SETUP) begin
                r_addr_mem <= addr_in;
            end else if (w_capture && !w_last_beat) begin
                r_addr_mem <= r_addr_mem + ADDR_W'(1);
            end
            if (w_capture) begin
                r_rd_data_out <= rd_data_mem;
            end
        end
    end

`ifdef D_MEM_RD_BURST_EN
    localparam int unsigned BEAT_W = ADDR_W + 1;

    logic [BEAT_W-1:0] r_beats_left;
    logic              r_beat_valid;

    assign w_last_beat = (r_beats_left == BEAT_W'(1));

    // Remaining beat count (zero length means one beat) and per-beat pulse.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_beats_left <= '0;
            r_beat_valid <= 1'b0;
        end else begin
            if (r_state == RD_SETUP) begin
                r_beats_left <= (rd_len == '0) ? BEAT_W'(1) : rd_len;
            end else if (w_capture) begin
                r_beats_left <= r_beats_left - BEAT_W'(1);
            end
            r_beat_valid <= w_capture;
        end
    end

    assign rd_beat_valid = r_beat_valid;
`else
    assign w_last_beat = 1'b1;
`endif

    assign addr_mem    = r_addr_mem;
    assign rd_data_out = r_rd_data_out;
    assign rd_enable   = r_state[ST_EN_BIT];
    assign rd_done     = r_state[ST_DONE_BIT];
    assign rd_busy     = r_state[ST_BUSY_BIT];

endmodule

// File: doc/d_memory_read_interface.md
Name: d_memory_read_interface

Overview:
Read-side companion to the D-memory write interface. Accepts a one-shot read request for a 32 x 8 decrypted-message RAM and drives the RAM address. It waits out the RAM's fixed read latency, registers the returned byte, and flags completion with a one-cycle rd_done pulse. Sits between the cracking/verification FSM and the D-memory port, using the same start/done handshake style as the writer.

Parameters:
ADDR_W, 5, RAM address width (depth 2^ADDR_W = 32)
DATA_W, 8, RAM data width
RD_LATENCY, 2, clk edges from addr_mem change to valid rd_data_mem (legal 1..7)

Ports:
clk  input  1  system clock, rising edge
nreset  input  1  reset, asynchronous, active-low
rd_start  input  1  read request, sampled only in IDLE
addr_in  input  ADDR_W  requested address, sampled in RD_SETUP
rd_data_mem  input  DATA_W  RAM q output
addr_mem  output  ADDR_W  registered RAM address
rd_enable  output  1  RAM rden, high throughout RD_WAIT
rd_data_out  output  DATA_W  captured read byte, held until next capture
rd_done  output  1  one-cycle completion pulse; rd_data_out valid while high
rd_busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset nreset is asynchronous, active-low.
- Reset values: state=IDLE, addr_mem=0, rd_data_out=0, wait counter=0, so rd_enable=0, rd_done=0, rd_busy=0.
- Assertion of nreset mid-operation aborts immediately. No rd_done is produced for the aborted request.
- States: IDLE, RD_SETUP, RD_WAIT, RD_DONE.
  - IDLE: stay until rd_start=1, then go to RD_SETUP.
  - RD_SETUP: addr_mem<=addr_in; cnt<=RD_LATENCY; go to RD_WAIT.
  - RD_WAIT: while cnt!=0, cnt<=cnt-1. At cnt==0: rd_data_out<=rd_data_mem, go to RD_DONE.
  - RD_DONE: rd_done=1 for exactly one cycle, then go to IDLE.
  - Illegal/default state: go to IDLE.
- Timing: rd_start sampled at edge N; addr_mem updates at N+1; capture at N+2+RD_LATENCY; rd_done high for the following cycle; IDLE at N+3+RD_LATENCY. For RD_LATENCY=2, rd_done is high between edges N+4 and N+5.
- Back-to-back: rd_start high in the cycle rd_done is high is ignored. The next request is accepted only from IDLE, so minimum spacing is RD_LATENCY+3 cycles.
- Changes to addr_in after RD_SETUP have no effect on the current read. rd_start while busy is ignored (no queuing).
- rd_enable, rd_done and rd_busy decode directly from the state register; no combinational path from inputs.
- Counter width is 3 bits; out-of-range RD_LATENCY is a compile-time assertion failure.

Optional Feature:
Macro: D_MEM_RD_BURST_EN
- Defined:
  - Adds input rd_len [ADDR_W:0] (sampled in RD_SETUP; 0 is treated as 1) and output rd_beat_valid (1 bit, reset 0).
  - After each capture, rd_beat_valid pulses one cycle with rd_data_out valid. addr_mem<=addr_mem+1, wrapping 31->0, and RD_WAIT is re-entered with cnt<=RD_LATENCY.
  - rd_done pulses only with the final beat (coincident with its rd_beat_valid).
  - rd_len=32 reads the whole RAM.
- Undefined: rd_len and rd_beat_valid ports do not exist; every request is a single read.

Decomposition:
- Package d_mem_pkg holds: ADDR_W/DATA_W/MEM_DEPTH constants, rd_state_t enum (state encodings, with flag bits for rd_enable/rd_done), and LAT_CNT_W.
- One natural sub-module: d_mem_latency_counter (load/decrement/zero flag), reusable by the writer.

Test Plan:
1. nreset low while in RD_WAIT -> all outputs 0 immediately; no rd_done after release.
2. RAM model (latency 2) with mem[5]=8'hA7; rd_start at edge 0, addr_in=5 -> addr_mem=5 after edge 1; rd_enable high edges 2-4; rd_data_out=8'hA7 and rd_done=1 for one cycle after edge 4.
3. rd_start held high continuously with addr_in stepping 0,1,2 -> one read per 5-cycle window. Data matches the addr_in latched in each RD_SETUP; no reads are dropped or duplicated.
4. addr_in changed to 9 during RD_WAIT of a read to 3 -> rd_data_out=mem[3].
5. RD_LATENCY=1 and 7 builds -> rd_done appears 3 and 9 cycles after the rd_start edge respectively.
6. D_MEM_RD_BURST_EN, addr_in=30, rd_len=4 -> beats from addresses 30, 31, 0, 1; four rd_beat_valid pulses; single rd_done with the 4th beat.
